// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: pcsource encodings, NOP word, datapath widths
// and the IF/ID payload layout.
package mips_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc4;
    } ifid_t;

    // 2'b11 is not a redirect; it falls back to sequential fetch.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PC_BR) || (sel == PC_JMP);
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer catching a fetch that completes while decode stalls.
// Zero-latency payload out; clear beats load beats drain.
module if_hold_buf
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  clrn,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  ifid_t load_dat,
    output logic  full,
    output ifid_t dat
);

    logic  full_q, full_d;
    ifid_t dat_q, dat_d;

    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            dat_d  = load_dat;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

    assign full = full_q;
    assign dat  = dat_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select, imem handshake, IF/ID register.
// IF_PERF_CNT_EN adds fetch/stall/flush counters; stall freezes IF/ID, the hold buffer absorbs one fetch.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              stall,
    input  logic [1:0]        pcsource,
    input  logic [ADDR_W-1:0] bpc,
    input  logic [ADDR_W-1:0] jpc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc4,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush,
`endif
    output logic              id_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic              vld_q, vld_d;
    logic              run_q;

    logic              redirect;
    logic              fetch_done;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    ifid_t             fetched;

    logic              buf_full;
    ifid_t             buf_dat;
    logic              buf_load;
    logic              buf_drain;

    // Request depends only on registers, never on this cycle's inputs.
    assign imem_req   = run_q & ~buf_full;
    assign imem_addr  = pc_q;
    assign fetch_done = imem_req & imem_ready;
    assign redirect   = is_redirect(pcsource);
    assign pc_plus4   = pc_q + 32'd4;
    assign target     = (pcsource == PC_BR) ? bpc : jpc;

    always_comb begin
        fetched.inst = imem_rdata;
        fetched.pc4  = pc_plus4;
    end

    assign buf_load  = stall & fetch_done & ~redirect;
    assign buf_drain = ~stall & buf_full;

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .clrn     (clrn),
        .load     (buf_load),
        .drain    (buf_drain),
        .clear    (redirect),
        .load_dat (fetched),
        .full     (buf_full),
        .dat      (buf_dat)
    );

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {target[ADDR_W-1:2], 2'b00};
        end else if (fetch_done) begin
            pc_d = pc_plus4;
        end
    end

    // A full buffer is older than anything memory could return, so it wins.
    always_comb begin
        ifid_d = ifid_q;
        vld_d  = vld_q;
        if (!stall) begin
            if (redirect) begin
                ifid_d.inst = NOP_INST;
                ifid_d.pc4  = '0;
                vld_d       = 1'b0;
            end else if (buf_full) begin
                ifid_d = buf_dat;
                vld_d  = 1'b1;
            end else if (fetch_done) begin
                ifid_d = fetched;
                vld_d  = 1'b1;
            end else begin
                ifid_d.inst = NOP_INST;
                ifid_d.pc4  = '0;
                vld_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
            vld_q  <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            vld_q  <= vld_d;
            run_q  <= 1'b1;
        end
    end

    assign id_inst  = ifid_q.inst;
    assign id_pc4   = ifid_q.pc4;
    assign id_valid = vld_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_done && !redirect) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall)                   stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect)                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch = fetch_cnt_q;
    assign perf_stall = stall_cnt_q;
    assign perf_flush = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: expected IF/ID entries queued as stimulus is driven,
// popped when the stage should present them; fetch address/request checked every cycle.
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .stall      (stall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
`ifdef IF_PERF_CNT_EN
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall),
        .perf_flush (perf_flush),
`endif
        .id_valid   (id_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    ifid_t       sb[$];
    logic [31:0] m_pc;
    logic        m_run, m_full, m_vld;
    logic [31:0] m_binst, m_bpc4, m_inst, m_pc4;
    logic [31:0] m_fetch, m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5671;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_pc = 32'h0; m_run = 1'b0; m_full = 1'b0; m_vld = 1'b0;
        m_binst = '0; m_bpc4 = '0; m_inst = '0; m_pc4 = '0;
        m_fetch = '0; m_stall = '0; m_flush = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_inst", id_inst, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch, 32'h0);
        check("rst_perf_stall", perf_stall, 32'h0);
        check("rst_perf_flush", perf_flush, 32'h0);
`endif
    endtask

    // Drive one cycle at the falling edge, predict, then check after the next rising edge.
    task automatic step(input logic s, input logic [1:0] ps, input logic [31:0] b,
                        input logic [31:0] j, input logic rdy);
        logic  redir, fd, push;
        ifid_t e;
        stall = s; pcsource = ps; bpc = b; jpc = j; imem_ready = rdy;
        imem_rdata = rdy ? mem_word(imem_addr) : 32'hBAD0_BAD0;

        redir = (ps == 2'b01) || (ps == 2'b10);
        fd    = m_run && !m_full && rdy;
        push  = 1'b0;
        if (!s && !redir) begin
            if (m_full) begin
                e.inst = m_binst; e.pc4 = m_bpc4; push = 1'b1;
            end else if (fd) begin
                e.inst = mem_word(m_pc); e.pc4 = m_pc + 32'd4; push = 1'b1;
            end
        end
        if (push) sb.push_back(e);
        if (fd && !redir) m_fetch++;
        if (s) m_stall++;
        if (redir) m_flush++;
        if (redir) m_full = 1'b0;
        else if (s && fd) begin
            m_full = 1'b1; m_binst = mem_word(m_pc); m_bpc4 = m_pc + 32'd4;
        end else if (!s) m_full = 1'b0;
        if (redir) m_pc = (ps == 2'b01 ? b : j) & 32'hFFFF_FFFC;
        else if (fd) m_pc = m_pc + 32'd4;
        m_run = 1'b1;

        @(negedge clk);
        if (!s) begin
            check("id_valid", {31'b0, id_valid}, {31'b0, push});
            if (push) begin
                if (sb.size() == 0) begin
                    check("sb_size", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("id_inst", id_inst, e.inst);
                    check("id_pc4", id_pc4, e.pc4);
                    m_inst = e.inst; m_pc4 = e.pc4; m_vld = 1'b1;
                end
            end else begin
                check("bubble_inst", id_inst, NOP_INST);
                m_inst = NOP_INST; m_vld = 1'b0;
            end
        end else begin
            check("hold_valid", {31'b0, id_valid}, {31'b0, m_vld});
            check("hold_inst", id_inst, m_inst);
            if (m_vld) check("hold_pc4", id_pc4, m_pc4);
        end
        check("imem_addr", imem_addr, m_pc);
        check("imem_req", {31'b0, imem_req}, {31'b0, (m_run && !m_full)});
    endtask

    task automatic seq(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, PC_SEQ, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        clrn = 1'b1;

        // Start-up and sequential fetch of 0, 4; then two wait states at PC 8.
        seq(3, 1'b1);
        seq(2, 1'b0);
        seq(2, 1'b1);
        // Branch to 0x40 (jpc differs so the wrong source would be visible).
        step(1'b0, PC_BR, 32'h0000_0040, 32'h0000_0999, 1'b1);
        seq(2, 1'b1);
        // pcsource 11 behaves as sequential.
        step(1'b0, 2'b11, 32'h0000_0080, 32'h0000_0080, 1'b1);
        // Jump with misaligned target: low bits forced to 00 -> 0x10.
        step(1'b0, PC_JMP, 32'h0000_0055, 32'h0000_0013, 1'b1);
        // Stall for 3 cycles while fetch of 0x10 completes into the hold buffer.
        for (int i = 0; i < 3; i++) step(1'b1, PC_SEQ, 32'h0, 32'h0, 1'b1);
        seq(3, 1'b1);
        // Stall + jump with buffer full: buffered word must be dropped.
        step(1'b1, PC_SEQ, 32'h0, 32'h0, 1'b1);
        step(1'b1, PC_JMP, 32'h0, 32'h0000_0100, 1'b1);
        seq(3, 1'b1);
        // Redirect during a wait state.
        step(1'b0, PC_BR, 32'h0000_0200, 32'h0, 1'b0);
        seq(1, 1'b0);
        seq(2, 1'b1);
        // PC wrap-around.
        step(1'b0, PC_JMP, 32'h0, 32'hFFFF_FFFC, 1'b1);
        seq(3, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_stall", perf_stall, m_stall);
        check("perf_flush", perf_flush, m_flush);
`endif

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 clrn = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        clrn = 1'b1;

        // Random traffic mix.
        for (int i = 0; i < 400; i++) begin
            logic       s, rdy;
            logic [1:0] ps;
            int         r;
            s   = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 15);
            ps  = (r == 0) ? PC_BR : (r == 1) ? PC_JMP : (r == 2) ? 2'b11 : PC_SEQ;
            step(s, ps, $urandom, $urandom, rdy);
        end
        seq(3, 1'b1);
        check("sb_final", 32'(sb.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_end", perf_fetch, m_fetch);
        check("perf_stall_end", perf_stall, m_stall);
        check("perf_flush_end", perf_flush, m_flush);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
